// File: rtl/axi_burst_master_pkg.sv
// rtl/axi_burst_master_pkg.sv - shared FSM state type, AXI constants and default AXI bus widths
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif

package axi_burst_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RADDR = 3'd1,
    ST_RDATA = 3'd2,
    ST_WADDR = 3'd3,
    ST_WDATA = 3'd4,
    ST_WRESP = 3'd5
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [2:0] SIZE_WORD  = 3'b010;

endpackage

// File: rtl/axi_burst_master.sv
// rtl/axi_burst_master.sv - single-outstanding AXI burst master; optional sticky response error via AXI_MASTER_RESP_ERR_EN
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif

module axi_burst_master
  import axi_burst_master_pkg::*;
#(
  parameter int MASTER_ID = 0,
  parameter int MAX_BEATS = 4,
  parameter int LW        = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  // CPU request side
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [`AXI_ADDR_BITS-1:0]  req_addr,
  input  logic [LW-1:0]              req_len,
  input  logic [`AXI_STRB_BITS-1:0]  req_strb,
  output logic [LW-1:0]              wbeat_idx,
  input  logic [`AXI_DATA_BITS-1:0]  wbeat_data,
  output logic                       rbeat_valid,
  output logic [LW-1:0]              rbeat_idx,
  output logic [`AXI_DATA_BITS-1:0]  rbeat_data,
  output logic                       done,
  output logic                       busy,
  // read address channel
  output logic                       arvalid,
  input  logic                       arready,
  output logic [`AXI_ID_BITS-1:0]    arid,
  output logic [`AXI_ADDR_BITS-1:0]  araddr,
  output logic [`AXI_LEN_BITS-1:0]   arlen,
  output logic [2:0]                 arsize,
  output logic [1:0]                 arburst,
  // read data channel
  input  logic                       rvalid,
  output logic                       rready,
  input  logic [`AXI_ID_BITS-1:0]    rid,
  input  logic [`AXI_DATA_BITS-1:0]  rdata,
  input  logic [1:0]                 rresp,
  input  logic                       rlast,
  // write address channel
  output logic                       awvalid,
  input  logic                       awready,
  output logic [`AXI_ID_BITS-1:0]    awid,
  output logic [`AXI_ADDR_BITS-1:0]  awaddr,
  output logic [`AXI_LEN_BITS-1:0]   awlen,
  output logic [2:0]                 awsize,
  output logic [1:0]                 awburst,
  // write data channel
  output logic                       wvalid,
  input  logic                       wready,
  output logic [`AXI_DATA_BITS-1:0]  wdata,
  output logic [`AXI_STRB_BITS-1:0]  wstrb,
  output logic                       wlast,
  // write response channel
  input  logic                       bvalid,
  output logic                       bready,
  input  logic [`AXI_ID_BITS-1:0]    bid,
`ifdef AXI_MASTER_RESP_ERR_EN
  output logic                       err,
  input  logic                       err_clr,
`endif
  input  logic [1:0]                 bresp
);

  localparam int ID_W  = `AXI_ID_BITS;
  localparam int LEN_W = `AXI_LEN_BITS;

  state_t                     r_state;
  logic                       r_req_ready;
  logic                       r_we;
  logic [`AXI_ADDR_BITS-1:0]  r_addr;
  logic [LW-1:0]              r_len;
  logic [`AXI_STRB_BITS-1:0]  r_strb;
  logic [LW-1:0]              r_beat;
  logic                       r_arvalid;
  logic                       r_rready;
  logic                       r_awvalid;
  logic                       r_wvalid;
  logic                       r_bready;

  logic w_accept;
  logic w_ar_hs;
  logic w_r_hs;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_beat_last;

  assign w_accept    = req_valid & r_req_ready;
  assign w_ar_hs     = r_arvalid & arready;
  assign w_r_hs      = r_rready & rvalid;
  assign w_aw_hs     = r_awvalid & awready;
  assign w_w_hs      = r_wvalid & wready;
  assign w_b_hs      = r_bready & bvalid;
  assign w_beat_last = (r_beat == r_len);

  // Transaction FSM: owns every VALID/READY flag so none depends combinationally on req_valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_len       <= '0;
      r_strb      <= '0;
      r_beat      <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // The first idle cycle after reset release only arms req_ready
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_we        <= req_we;
            r_addr      <= req_addr;
            r_len       <= req_len;
            r_strb      <= req_strb;
            r_beat      <= '0;
            if (req_we) begin
              r_state   <= ST_WADDR;
              r_awvalid <= 1'b1;
            end else begin
              r_state   <= ST_RADDR;
              r_arvalid <= 1'b1;
            end
          end
        end
        ST_RADDR: begin
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (w_r_hs) begin
            if (rlast) begin
              // The slave's RLAST ends the burst even if fewer or more beats arrived
              r_rready    <= 1'b0;
              r_beat      <= '0;
              r_req_ready <= 1'b1;
              r_state     <= ST_IDLE;
            end else if (!w_beat_last) begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        ST_WADDR: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b1;
            r_state   <= ST_WDATA;
          end
        end
        ST_WDATA: begin
          if (w_w_hs) begin
            if (w_beat_last) begin
              r_wvalid <= 1'b0;
              r_bready <= 1'b1;
              r_beat   <= '0;
              r_state  <= ST_WRESP;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        ST_WRESP: begin
          if (w_b_hs) begin
            r_bready    <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b0;
          r_arvalid   <= 1'b0;
          r_rready    <= 1'b0;
          r_awvalid   <= 1'b0;
          r_wvalid    <= 1'b0;
          r_bready    <= 1'b0;
        end
      endcase
    end
  end

  // CPU side: busy is decoded from state so it stays low during and just after reset
  assign req_ready   = r_req_ready;
  assign busy        = (r_state != ST_IDLE);
  assign done        = r_we ? w_b_hs : (w_r_hs & rlast);
  assign wbeat_idx   = r_beat;
  assign rbeat_valid = w_r_hs;
  assign rbeat_idx   = r_beat;
  assign rbeat_data  = rdata;

  // Address channels share the latched request payload
  assign arvalid = r_arvalid;
  assign arid    = ID_W'(MASTER_ID);
  assign araddr  = r_addr;
  assign arlen   = {{(LEN_W-LW){1'b0}}, r_len};
  assign arsize  = SIZE_WORD;
  assign arburst = BURST_INCR;
  assign rready  = r_rready;

  assign awvalid = r_awvalid;
  assign awid    = ID_W'(MASTER_ID);
  assign awaddr  = r_addr;
  assign awlen   = {{(LEN_W-LW){1'b0}}, r_len};
  assign awsize  = SIZE_WORD;
  assign awburst = BURST_INCR;

  // Write data is passed straight through from the CPU for the requested beat
  assign wvalid = r_wvalid;
  assign wdata  = wbeat_data;
  assign wstrb  = r_strb;
  assign wlast  = r_wvalid & w_beat_last;
  assign bready = r_bready;

`ifdef AXI_MASTER_RESP_ERR_EN
  logic r_err;
  logic w_err_set;
  logic w_unused_ids;

  assign w_err_set    = (w_r_hs & (rresp != RESP_OKAY)) | (w_b_hs & (bresp != RESP_OKAY));
  assign w_unused_ids = ^{rid, bid};

  // Sticky error flag; a new error in the same cycle as a clear keeps it set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign err = r_err;
`else
  logic w_unused_resp;
  assign w_unused_resp = ^{rid, bid, rresp, bresp};
`endif

endmodule
